// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache between the CPU
// memory stage and DataMemory; read misses refill a 4-word line one word per cycle.
module data_cache #(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int INDEX_BITS    = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [ADDRESS_WIDTH-1:0] cpu_a,
   input  logic [DATA_WIDTH-1:0]    cpu_wd,
   input  logic                     cpu_we,
   input  logic                     cpu_re,
   input  logic                     cpu_adtp,
   output logic [DATA_WIDTH-1:0]    cpu_rd,
   output logic                     stall,
   output logic [ADDRESS_WIDTH-1:0] mem_a,
   output logic [DATA_WIDTH-1:0]    mem_wd,
   output logic                     mem_we,
   output logic                     mem_adtp,
   input  logic [DATA_WIDTH-1:0]    mem_rd
);

   localparam int LINES   = 1 << INDEX_BITS;
   localparam int TAG_W   = ADDRESS_WIDTH - 4 - INDEX_BITS;
   localparam int LADDR_W = INDEX_BITS + 2;

   typedef enum logic {IDLE, FILL} state_t;

   state_t                  state_q, state_d;
   logic [1:0]              cnt_q, cnt_d;
   logic [LINES-1:0]        valid_q;
   logic [TAG_W-1:0]        tag_mem  [LINES];
   logic [DATA_WIDTH-1:0]   word_mem [LINES*4];
   logic [TAG_W-1:0]        fill_tag_q;
   logic [INDEX_BITS-1:0]   fill_idx_q;

   logic [TAG_W-1:0]        a_tag;
   logic [INDEX_BITS-1:0]   a_idx;
   logic [1:0]              a_word;
   logic [1:0]              a_byte;
   logic                    hit;
   logic                    misaligned;
   logic [DATA_WIDTH-1:0]   cur_word;

   logic                    arr_we;
   logic [LADDR_W-1:0]      arr_waddr;
   logic [DATA_WIDTH-1:0]   arr_wdata;
   logic                    fill_start;
   logic                    fill_done;
   logic                    line_inval;

   function automatic logic [7:0] get_byte(input logic [DATA_WIDTH-1:0] w,
                                           input logic [1:0] sel);
      logic [7:0] b;
      case (sel)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      return b;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] put_byte(input logic [DATA_WIDTH-1:0] w,
                                                      input logic [1:0] sel,
                                                      input logic [7:0] b);
      logic [DATA_WIDTH-1:0] r;
      r = w;
      case (sel)
         2'd0:    r[7:0]   = b;
         2'd1:    r[15:8]  = b;
         2'd2:    r[23:16] = b;
         default: r[31:24] = b;
      endcase
      return r;
   endfunction

   assign a_tag      = cpu_a[ADDRESS_WIDTH-1 -: TAG_W];
   assign a_idx      = cpu_a[3+INDEX_BITS:4];
   assign a_word     = cpu_a[3:2];
   assign a_byte     = cpu_a[1:0];
   assign hit        = valid_q[a_idx] && (tag_mem[a_idx] == a_tag);
   assign misaligned = !cpu_adtp && (a_byte != 2'b00);
   assign cur_word   = word_mem[{a_idx, a_word}];

   // Next-state and output decode; everything stays quiet while rst is high
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      stall      = 1'b0;
      cpu_rd     = '0;
      mem_a      = cpu_a;
      mem_wd     = cpu_wd;
      mem_we     = 1'b0;
      mem_adtp   = cpu_adtp;
      arr_we     = 1'b0;
      arr_waddr  = {a_idx, a_word};
      arr_wdata  = cpu_wd;
      fill_start = 1'b0;
      fill_done  = 1'b0;
      line_inval = 1'b0;
      if (!rst) begin
         case (state_q)
            IDLE: begin
               mem_we = cpu_we;
               if (cpu_we) begin
                  if (misaligned) begin
                     line_inval = hit;
                  end else if (hit) begin
                     arr_we    = 1'b1;
                     arr_wdata = cpu_adtp ? put_byte(cur_word, a_byte, cpu_wd[7:0]) : cpu_wd;
                  end
               end else if (cpu_re) begin
                  if (misaligned) begin
                     cpu_rd = mem_rd;
                  end else if (hit) begin
                     cpu_rd = cpu_adtp ? {{(DATA_WIDTH-8){1'b0}}, get_byte(cur_word, a_byte)}
                                       : cur_word;
                  end else begin
                     stall      = 1'b1;
                     fill_start = 1'b1;
                     state_d    = FILL;
                     cnt_d      = 2'd0;
                  end
               end
            end
            FILL: begin
               stall     = 1'b1;
               mem_adtp  = 1'b0;
               mem_a     = {fill_tag_q, fill_idx_q, cnt_q, 2'b00};
               arr_we    = 1'b1;
               arr_waddr = {fill_idx_q, cnt_q};
               arr_wdata = mem_rd;
               cnt_d     = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  fill_done = 1'b1;
                  state_d   = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Control state: FSM, fill counter and valid bits
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 2'd0;
         valid_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (line_inval) valid_q[a_idx] <= 1'b0;
         if (fill_done) valid_q[fill_idx_q] <= 1'b1;
      end
   end

   // Data storage: line words, tags and the captured refill target
   always_ff @(posedge clk) begin
      if (arr_we) word_mem[arr_waddr] <= arr_wdata;
      if (fill_start) begin
         fill_tag_q <= a_tag;
         fill_idx_q <= a_idx;
      end
      if (fill_done) tag_mem[fill_idx_q] <= fill_tag_q;
   end

endmodule

// File: tb/tb_data_cache.sv
// Bench for data_cache: byte-array DataMemory, a rule-level cache model checked
// every cycle, and directed scenarios with hand-computed expectations.
module tb_data_cache;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] cpu_a = 32'h0;
   logic [31:0] cpu_wd = 32'h0;
   logic        cpu_we = 1'b0;
   logic        cpu_re = 1'b0;
   logic        cpu_adtp = 1'b0;
   logic [31:0] cpu_rd;
   logic        stall;
   logic [31:0] mem_a;
   logic [31:0] mem_wd;
   logic        mem_we;
   logic        mem_adtp;
   logic [31:0] mem_rd;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   data_cache dut (
      .clk(clk), .rst(rst),
      .cpu_a(cpu_a), .cpu_wd(cpu_wd), .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_adtp(cpu_adtp),
      .cpu_rd(cpu_rd), .stall(stall),
      .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_adtp(mem_adtp), .mem_rd(mem_rd)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // DataMemory: combinational read, write captured at negedge and applied at posedge
   logic [7:0]  mem [0:4095];
   logic [11:0] ma;
   logic        pw_en = 1'b0;
   logic [11:0] pw_a;
   logic [31:0] pw_wd;
   logic        pw_adtp;

   assign ma     = mem_a[11:0];
   assign mem_rd = mem_adtp ? {24'h0, mem[ma]}
                            : {mem[ma+12'd3], mem[ma+12'd2], mem[ma+12'd1], mem[ma]};

   initial begin
      logic [31:0] init_w [4];
      init_w = '{32'h11111111, 32'h44332211, 32'h33333333, 32'h44444444};
      for (int i = 0; i < 4096; i++) mem[i] = 8'(i * 7 + 3);
      for (int j = 0; j < 4; j++)
         for (int b = 0; b < 4; b++)
            mem[12'(256 + j*4 + b)] = init_w[j][8*b +: 8];
      forever begin
         @(posedge clk);
         if (pw_en) begin
            if (pw_adtp) begin
               mem[pw_a] <= pw_wd[7:0];
            end else begin
               mem[pw_a]        <= pw_wd[7:0];
               mem[pw_a+12'd1]  <= pw_wd[15:8];
               mem[pw_a+12'd2]  <= pw_wd[23:16];
               mem[pw_a+12'd3]  <= pw_wd[31:24];
            end
         end
      end
   end

   // Reference model: which lines are resident, and how much refill remains.
   // Resident data always equals memory because the cache is write-through.
   bit          m_valid [16];
   logic [23:0] m_tag   [16];
   int          m_fill_left = 0;
   logic [31:0] m_base = 32'h0;

   always @(negedge clk) begin
      logic        e_stall, e_we, e_adtp, chk_addr, hitm, mis;
      logic [31:0] e_rd, e_a;
      logic [3:0]  idx;
      logic [11:0] ca;
      idx  = cpu_a[7:4];
      ca   = cpu_a[11:0];
      hitm = m_valid[idx] && (m_tag[idx] == cpu_a[31:8]);
      mis  = !cpu_adtp && (cpu_a[1:0] != 2'b00);
      e_stall = 1'b0; e_we = 1'b0; e_rd = 32'h0; e_a = cpu_a; e_adtp = cpu_adtp; chk_addr = 1'b1;
      if (rst) begin
         chk_addr = 1'b0;
      end else if (m_fill_left > 0) begin
         e_stall = 1'b1;
         e_adtp  = 1'b0;
         e_a     = m_base + 32'(4 * (4 - m_fill_left));
      end else begin
         e_we = cpu_we;
         if (!cpu_we && cpu_re) begin
            if (mis || hitm)
               e_rd = cpu_adtp ? {24'h0, mem[ca]}
                               : {mem[ca+12'd3], mem[ca+12'd2], mem[ca+12'd1], mem[ca]};
            else
               e_stall = 1'b1;
         end
      end
      check("stall", {31'h0, stall}, {31'h0, e_stall});
      check("mem_we", {31'h0, mem_we}, {31'h0, e_we});
      check("cpu_rd", cpu_rd, e_rd);
      if (chk_addr) begin
         check("mem_a", mem_a, e_a);
         check("mem_adtp", {31'h0, mem_adtp}, {31'h0, e_adtp});
      end
      if (e_we) check("mem_wd", mem_wd, cpu_wd);

      pw_en   = mem_we;
      pw_a    = mem_a[11:0];
      pw_wd   = mem_wd;
      pw_adtp = mem_adtp;

      if (rst) begin
         for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
         m_fill_left = 0;
      end else if (m_fill_left > 0) begin
         m_fill_left--;
         if (m_fill_left == 0) begin
            m_valid[m_base[7:4]] = 1'b1;
            m_tag[m_base[7:4]]   = m_base[31:8];
         end
      end else if (cpu_we) begin
         if (mis && hitm) m_valid[idx] = 1'b0;
      end else if (cpu_re && !mis && !hitm) begin
         m_fill_left = 4;
         m_base      = {cpu_a[31:4], 4'h0};
      end
   end

   logic [31:0] fa [8];

   task automatic idle();
      cpu_we = 1'b0; cpu_re = 1'b0;
   endtask

   // Issue a load, count stall cycles, record mem_a per stalled cycle
   task automatic do_load(input logic [31:0] a, input logic adtp,
                          output logic [31:0] rd, output int ns);
      bit done;
      cpu_a = a; cpu_adtp = adtp; cpu_we = 1'b0; cpu_re = 1'b1;
      ns = 0; done = 1'b0; rd = 32'h0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (!stall) begin
            rd = cpu_rd; done = 1'b1;
            break;
         end
         if (ns < 8) fa[ns] = mem_a;
         ns++;
         @(posedge clk); #1;
      end
      check("load_completes", {31'h0, done}, 32'h1);
      @(posedge clk); #1;
      idle();
   endtask

   task automatic do_store(input logic [31:0] a, input logic [31:0] wd, input logic adtp);
      cpu_a = a; cpu_wd = wd; cpu_adtp = adtp; cpu_we = 1'b1; cpu_re = 1'b0;
      @(negedge clk); #1;
      check("store_mem_we", {31'h0, mem_we}, 32'h1);
      check("store_no_stall", {31'h0, stall}, 32'h0);
      @(posedge clk); #1;
      idle();
   endtask

   initial begin
      logic [31:0] rd;
      int ns;
      cpu_a = 32'h300; cpu_wd = 32'hDEADBEEF; cpu_we = 1'b1; cpu_re = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check("reset_stall", {31'h0, stall}, 32'h0);
      check("reset_mem_we", {31'h0, mem_we}, 32'h0);
      check("reset_cpu_rd", cpu_rd, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0; idle();
      @(posedge clk); #1;

      do_load(32'h104, 1'b0, rd, ns);
      check("miss_stall_cycles", 32'(ns), 32'd5);
      check("fill_a0", fa[1], 32'h100);
      check("fill_a1", fa[2], 32'h104);
      check("fill_a2", fa[3], 32'h108);
      check("fill_a3", fa[4], 32'h10C);
      check("miss_rd", rd, 32'h44332211);
      do_load(32'h10C, 1'b0, rd, ns);
      check("hit_stall", 32'(ns), 32'd0);
      check("hit_rd", rd, 32'h44444444);
      do_load(32'h106, 1'b1, rd, ns);
      check("byte_hit_stall", 32'(ns), 32'd0);
      check("byte_hit_rd", rd, 32'h00000033);

      do_store(32'h105, 32'h000000AB, 1'b1);
      do_load(32'h104, 1'b0, rd, ns);
      check("after_bstore_stall", 32'(ns), 32'd0);
      check("after_bstore_rd", rd, 32'h4433AB11);
      check("mem_after_bstore", {mem[12'h107], mem[12'h106], mem[12'h105], mem[12'h104]},
            32'h4433AB11);

      do_load(32'h100, 1'b0, rd, ns);
      check("conf_first_stall", 32'(ns), 32'd0);
      check("conf_first_rd", rd, 32'h11111111);
      do_load(32'h200, 1'b0, rd, ns);
      check("conf_evict_stall", 32'(ns), 32'd5);
      do_load(32'h100, 1'b0, rd, ns);
      check("conf_remiss_stall", 32'(ns), 32'd5);
      check("conf_remiss_rd", rd, 32'h11111111);

      cpu_a = 32'h101; cpu_adtp = 1'b0; cpu_re = 1'b1; cpu_we = 1'b0;
      @(negedge clk); #1;
      check("mis_stall", {31'h0, stall}, 32'h0);
      check("mis_rd", cpu_rd, 32'h11111111);
      check("mis_mem_a", mem_a, 32'h101);
      check("mis_mem_adtp", {31'h0, mem_adtp}, 32'h0);
      @(posedge clk); #1;
      idle();
      do_load(32'h105, 1'b0, rd, ns);
      check("mis105_stall", 32'(ns), 32'd0);
      check("mis105_rd", rd, 32'h334433AB);
      do_load(32'h100, 1'b0, rd, ns);
      check("mis_keeps_valid", 32'(ns), 32'd0);

      do_store(32'h300, 32'hCAFEF00D, 1'b0);
      do_load(32'h300, 1'b0, rd, ns);
      check("no_alloc_stall", 32'(ns), 32'd5);
      check("no_alloc_rd", rd, 32'hCAFEF00D);

      cpu_a = 32'h304; cpu_wd = 32'h12345678; cpu_adtp = 1'b0; cpu_we = 1'b1; cpu_re = 1'b1;
      @(negedge clk); #1;
      check("both_cpu_rd", cpu_rd, 32'h0);
      check("both_mem_we", {31'h0, mem_we}, 32'h1);
      @(posedge clk); #1;
      idle();
      do_load(32'h304, 1'b0, rd, ns);
      check("both_store_hit_stall", 32'(ns), 32'd0);
      check("both_store_hit_rd", rd, 32'h12345678);

      do_store(32'h301, 32'h0A0B0C0D, 1'b0);
      do_load(32'h300, 1'b0, rd, ns);
      check("mis_store_inval_stall", 32'(ns), 32'd5);
      check("mis_store_inval_rd", rd, 32'h0B0C0D0D);

      cpu_a = 32'h104; cpu_adtp = 1'b0; cpu_re = 1'b1; cpu_we = 1'b0;
      @(negedge clk); #1;
      check("rf_miss_stall", {31'h0, stall}, 32'h1);
      @(posedge clk); #1;
      @(negedge clk); #1;
      check("rf_fill1_stall", {31'h0, stall}, 32'h1);
      @(posedge clk); #1;
      rst = 1'b1; cpu_we = 1'b1;
      @(negedge clk); #1;
      check("rf_reset_stall", {31'h0, stall}, 32'h0);
      check("rf_reset_mem_we", {31'h0, mem_we}, 32'h0);
      check("rf_reset_cpu_rd", cpu_rd, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0; cpu_we = 1'b0;
      do_load(32'h104, 1'b0, rd, ns);
      check("rf_reissue_stall", 32'(ns), 32'd5);
      check("rf_reissue_rd", rd, 32'h4433AB11);

      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
